regfile_wb_scheduler: RTL and testbench

- Register-file controller for the 7-stage pipeline. Owns the single register-file write port and keeps a per-register pending scoreboard.
- Issue stage checks the scoreboard before dispatch; stalls on RAW/WAW hazards.
- Arbitrates ALU and memory writeback requests round-robin onto the write port (write_to_rd, rd, rd_value). Output stage is registered.

---
 rtl/regfile_wb_scheduler.sv | 109 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port owner: pending scoreboard for issue hazards plus round-robin ALU/MEM writeback arbitration.
// Optional macro SCOREBOARD_BYPASS_EN lets the hazard check ignore the tag being granted this cycle.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module regfile_wb_scheduler #(
  parameter int TAG_W  = 5,
  parameter int WORD_W = `WORD_SIZE,
  parameter int PERF_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [TAG_W-1:0]  issue_rs1,
  input  logic [TAG_W-1:0]  issue_rs2,
  input  logic [TAG_W-1:0]  issue_rd,
  input  logic              issue_writes_rd,
  output logic              issue_ready,
  input  logic              alu_wb_valid,
  input  logic [TAG_W-1:0]  alu_wb_rd,
  input  logic [WORD_W-1:0] alu_wb_value,
  output logic              alu_wb_ready,
  input  logic              mem_wb_valid,
  input  logic [TAG_W-1:0]  mem_wb_rd,
  input  logic [WORD_W-1:0] mem_wb_value,
  output logic              mem_wb_ready,
  output logic              write_to_rd,
  output logic [TAG_W-1:0]  rd,
  output logic [WORD_W-1:0] rd_value,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int NREG = 1 << TAG_W;

  typedef enum logic {PRIO_MEM = 1'b0, PRIO_ALU = 1'b1} prio_t;

  prio_t             prio_reg, prio_next;
  logic [NREG-1:0]   pending_reg, pending_next, pending_eff;
  logic              alu_grant, mem_grant, grant_valid;
  logic [TAG_W-1:0]  grant_rd;
  logic [WORD_W-1:0] grant_value;
  logic              hazard, issue_fire;

  // prio names the port that wins the next contended cycle
  assign alu_grant   = alu_wb_valid & (~mem_wb_valid | (prio_reg == PRIO_ALU));
  assign mem_grant   = mem_wb_valid & (~alu_wb_valid | (prio_reg == PRIO_MEM));
  assign grant_valid = alu_grant | mem_grant;
  assign grant_rd    = alu_grant ? alu_wb_rd : mem_wb_rd;
  assign grant_value = alu_grant ? alu_wb_value : mem_wb_value;
  assign alu_wb_ready = alu_grant;
  assign mem_wb_ready = mem_grant;

  always_comb begin
    prio_next = prio_reg;
    if (alu_wb_valid && mem_wb_valid)
      prio_next = (prio_reg == PRIO_MEM) ? PRIO_ALU : PRIO_MEM;
  end

  assign hazard = pending_eff[issue_rs1] | pending_eff[issue_rs2] |
                  (issue_writes_rd & pending_eff[issue_rd]);
  assign issue_ready = ~hazard & ~flush;
  assign issue_fire  = issue_valid & issue_ready;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign pending_eff[gi]  = 1'b0;
        assign pending_next[gi] = 1'b0;
      end else begin : g_tag
        logic set_bit, clr_bit;
        assign set_bit = issue_fire & issue_writes_rd & (issue_rd == TAG_W'(gi));
        assign clr_bit = grant_valid & (grant_rd == TAG_W'(gi));
`ifdef SCOREBOARD_BYPASS_EN
        assign pending_eff[gi] = pending_reg[gi] & ~clr_bit;
`else
        assign pending_eff[gi] = pending_reg[gi];
`endif
        // set wins over a same-edge clear
        assign pending_next[gi] = flush ? 1'b0 : (set_bit | (pending_reg[gi] & ~clr_bit));
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg  <= '0;
      prio_reg     <= PRIO_MEM;
      write_to_rd  <= 1'b0;
      rd           <= '0;
      rd_value     <= '0;
      stall_cycles <= '0;
    end else begin
      pending_reg <= pending_next;
      prio_reg    <= prio_next;
      if (grant_valid) begin
        write_to_rd <= (grant_rd != '0);
        rd          <= grant_rd;
        rd_value    <= grant_value;
      end else begin
        write_to_rd <= 1'b0;
      end
      if (issue_valid && !issue_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: expected RF writes are queued at grant time and checked by a monitor.
module tb_regfile_wb_scheduler;
  localparam int TAG_W = 5, WORD_W = 32, PERF_W = 32;

  logic              clock = 1'b0;
  logic              reset_n, flush, issue_valid, issue_writes_rd;
  logic [TAG_W-1:0]  issue_rs1, issue_rs2, issue_rd;
  logic              issue_ready;
  logic              alu_wb_valid, alu_wb_ready, mem_wb_valid, mem_wb_ready;
  logic [TAG_W-1:0]  alu_wb_rd, mem_wb_rd, rd;
  logic [WORD_W-1:0] alu_wb_value, mem_wb_value, rd_value;
  logic              write_to_rd;
  logic [PERF_W-1:0] stall_cycles;

  int tests = 0;
  int fails = 0;
  int exp_stall = 0;
  logic [TAG_W+WORD_W-1:0] exp_q[$];

  regfile_wb_scheduler dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_writes_rd(issue_writes_rd), .issue_ready(issue_ready),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_value(alu_wb_value),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_value(mem_wb_value),
    .mem_wb_ready(mem_wb_ready),
    .write_to_rd(write_to_rd), .rd(rd), .rd_value(rd_value), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic v, input logic [TAG_W-1:0] rs1, input logic [TAG_W-1:0] rs2,
                       input logic [TAG_W-1:0] d, input logic w);
    issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = d; issue_writes_rd = w;
  endtask

  task automatic alu(input logic v, input logic [TAG_W-1:0] d, input logic [WORD_W-1:0] val);
    alu_wb_valid = v; alu_wb_rd = d; alu_wb_value = val;
  endtask

  task automatic mem(input logic v, input logic [TAG_W-1:0] d, input logic [WORD_W-1:0] val);
    mem_wb_valid = v; mem_wb_rd = d; mem_wb_value = val;
  endtask

  // Monitor: every RF write must match the oldest queued expectation
  always @(negedge clock) begin
    if (reset_n && write_to_rd) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL rf_write: got rd=%0d value=%0h, expected no write", rd, rd_value);
      end else begin
        logic [TAG_W+WORD_W-1:0] e;
        e = exp_q.pop_front();
        if ({rd, rd_value} !== e) begin
          fails++;
          $display("[TB] FAIL rf_write: got rd=%0d value=%0h, expected rd=%0d value=%0h",
                   rd, rd_value, e[TAG_W+WORD_W-1:WORD_W], e[WORD_W-1:0]);
        end else begin
          $display("[TB] rf_write rd=%0d value=%0h", rd, rd_value);
        end
      end
    end
  end

  initial begin
    logic bypass;
`ifdef SCOREBOARD_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    reset_n = 1'b0; flush = 1'b0;
    issue(0, 0, 0, 0, 0); alu(0, 0, 0); mem(0, 0, 0);
    #12;
    check("reset_write_to_rd", 64'(write_to_rd), 0);
    check("reset_rd", 64'(rd), 0);
    check("reset_rd_value", 64'(rd_value), 0);
    check("reset_stall", 64'(stall_cycles), 0);
    check("reset_issue_ready", 64'(issue_ready), 1);
    tick(); reset_n = 1'b1;

    // RAW on x5 resolved by an ALU writeback
    tick(); issue(1, 0, 0, 5, 1); #1; check("set5_ready", 64'(issue_ready), 1);
    tick(); issue(1, 5, 0, 0, 0); #1; check("raw5_stall", 64'(issue_ready), 0); exp_stall++;
    tick(); check("stall_after_1", 64'(stall_cycles), 1);
    alu(1, 5, 32'h1234); #1;
    check("alu5_grant", 64'(alu_wb_ready), 1);
    check("raw5_grant_cycle", 64'(issue_ready), 64'(bypass));
    if (!bypass) exp_stall++;
    exp_q.push_back({5'd5, 32'h1234});
    tick(); alu(0, 0, 0); #1;
    check("raw5_released", 64'(issue_ready), 1);
    check("stall_after_raw", 64'(stall_cycles), 64'(exp_stall));
    issue(0, 0, 0, 0, 0);

    // Contention: MEM first, then ALU
    tick(); alu(1, 3, 32'hA); mem(1, 4, 32'hB); #1;
    check("cont1_mem_ready", 64'(mem_wb_ready), 1);
    check("cont1_alu_ready", 64'(alu_wb_ready), 0);
    exp_q.push_back({5'd4, 32'hB});
    tick(); #1;
    check("cont2_alu_ready", 64'(alu_wb_ready), 1);
    check("cont2_mem_ready", 64'(mem_wb_ready), 0);
    exp_q.push_back({5'd3, 32'hA});

    // Write to x0 is consumed without effect on pending
    tick(); alu(0, 0, 0); mem(0, 0, 0); issue(1, 0, 0, 6, 1);
    tick(); issue(0, 0, 0, 0, 0); mem(1, 0, 32'hFFFF); #1;
    check("x0_mem_ready", 64'(mem_wb_ready), 1);
    tick(); mem(0, 0, 0); issue(1, 6, 0, 0, 0); #1;
    check("x0_no_write", 64'(write_to_rd), 0);
    check("x0_rd_tag", 64'(rd), 0);
    check("x0_pending6_kept", 64'(issue_ready), 0); exp_stall++;
    tick(); alu(1, 6, 32'h66); #1;
    check("clr6_grant_cycle", 64'(issue_ready), 64'(bypass));
    if (!bypass) exp_stall++;
    exp_q.push_back({5'd6, 32'h66});
    tick(); alu(0, 0, 0); #1; check("clr6_released", 64'(issue_ready), 1);

    // Issue with rd=0 never creates a hazard
    tick(); issue(1, 0, 0, 0, 1); #1; check("rd0_issue", 64'(issue_ready), 1);
    tick(); issue(1, 0, 0, 0, 0); #1; check("rs0_issue", 64'(issue_ready), 1);

    // Flush clears pending bits
    tick(); issue(1, 0, 0, 7, 1); #1; check("set7_ready", 64'(issue_ready), 1);
    tick(); issue(1, 0, 0, 9, 1); #1; check("set9_ready", 64'(issue_ready), 1);
    tick(); flush = 1'b1; issue(1, 7, 9, 0, 0); #1; check("flush_ready", 64'(issue_ready), 0); exp_stall++;
    tick(); flush = 1'b0; #1; check("post_flush_ready", 64'(issue_ready), 1);
    check("stall_before_reset", 64'(stall_cycles), 64'(exp_stall));

    // Reset while a grant is in flight; prio left at ALU beforehand
    tick(); issue(1, 0, 0, 10, 1);
    tick(); issue(0, 0, 0, 0, 0); alu(1, 11, 32'h55); mem(1, 15, 32'h5F); #1;
    check("pre_rst_mem_ready", 64'(mem_wb_ready), 1);
    exp_q.push_back({5'd15, 32'h5F});
    tick(); mem(0, 0, 0); alu(1, 12, 32'h77); #1;
    check("pre_rst_alu_ready", 64'(alu_wb_ready), 1);
    @(negedge clock); #1;
    reset_n = 1'b0; #1;
    check("rst_write_to_rd", 64'(write_to_rd), 0);
    check("rst_rd", 64'(rd), 0);
    check("rst_rd_value", 64'(rd_value), 0);
    check("rst_stall", 64'(stall_cycles), 0);
    alu(0, 0, 0);
    tick(); tick(); reset_n = 1'b1;
    tick(); issue(1, 10, 0, 0, 0); alu(1, 13, 32'hC); mem(1, 14, 32'hD); #1;
    check("post_rst_pending_clear", 64'(issue_ready), 1);
    check("post_rst_prio_mem", 64'(mem_wb_ready), 1);
    check("post_rst_alu_loses", 64'(alu_wb_ready), 0);
    exp_q.push_back({5'd14, 32'hD});
    tick(); issue(0, 0, 0, 0, 0); mem(0, 0, 0); #1;
    check("post_rst_alu_ready", 64'(alu_wb_ready), 1);
    exp_q.push_back({5'd13, 32'hC});
    tick(); alu(0, 0, 0);
    tick(); tick();
    check("queue_drained", 64'(exp_q.size()), 0);
    check("post_rst_stall", 64'(stall_cycles), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
